// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for handshaked pipeline-stage registers.
// The EX/MEM field widths and control-word layout live here. The skid FSM
// state encoding and its occupancy mapping also live here.
package pipe_pkg;

    localparam int XLEN         = 64;
    localparam int REGADDR_W    = 5;
    localparam int EXMEM_DATA_W = 3 * XLEN + REGADDR_W;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memtoreg;
        logic memwrite;
        logic regwrite;
        logic zero;
    } exmem_ctrl_t;

    localparam int EXMEM_CTRL_W = $bits(exmem_ctrl_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    // Number of beats held in a given skid state.
    function automatic logic [1:0] state_occupancy(input skid_state_t st);
        logic [1:0] occ;
        case (st)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One storage slot of a pipeline stage. It holds a valid bit, a control word
// and a data word. A clear drops valid and ctrl but leaves the data word
// alone, so a squashed slot looks like a NOP without extra data-path enables.
module pipe_slot #(
    parameter int DATA_W = 197,
    parameter int CTRL_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] next_ctrl,
    input  logic [DATA_W-1:0] next_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_r;
    logic [CTRL_W-1:0] ctrl_r;
    logic [DATA_W-1:0] data_r;

    // Slot register: clear beats load, and data is only written on load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else if (clear) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            ctrl_r  <= next_ctrl;
            data_r  <= next_data;
        end
    end

    assign valid = valid_r;
    assign ctrl  = ctrl_r;
    assign data  = data_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with an optional 2-entry skid buffer.
// SKID=1 gives a registered in_ready through a main and a skid slot.
// SKID=0 gives a single slot with a combinational in_ready.
// A flush squashes held and incoming beats. The data words are kept;
// only valid and ctrl are cleared.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int          DATA_W = EXMEM_DATA_W,
    parameter int          CTRL_W = EXMEM_CTRL_W,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    skid_state_t       state_r;
    skid_state_t       state_next_s;
    logic [1:0]        occupancy_r;
    logic              in_ready_r;

    logic              accept_s;
    logic              release_s;

    logic              main_valid_s;
    logic              main_load_s;
    logic              main_clear_s;
    logic              main_from_skid_s;
    logic [CTRL_W-1:0] main_ctrl_s;
    logic [DATA_W-1:0] main_data_s;
    logic [CTRL_W-1:0] main_next_ctrl_s;
    logic [DATA_W-1:0] main_next_data_s;

    logic              skid_valid_s;
    logic              skid_load_s;
    logic              skid_clear_s;
    logic [CTRL_W-1:0] skid_ctrl_s;
    logic [DATA_W-1:0] skid_data_s;

    assign accept_s  = in_valid && in_ready;
    assign release_s = main_valid_s && out_ready;

    // On a TWO->ONE release the main slot refills from the skid slot.
    // Otherwise it takes the upstream beat.
    assign main_next_ctrl_s = main_from_skid_s ? skid_ctrl_s : in_ctrl;
    assign main_next_data_s = main_from_skid_s ? skid_data_s : in_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk       (clk),
        .reset     (reset),
        .load      (main_load_s),
        .clear     (main_clear_s),
        .next_ctrl (main_next_ctrl_s),
        .next_data (main_next_data_s),
        .valid     (main_valid_s),
        .ctrl      (main_ctrl_s),
        .data      (main_data_s)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .reset     (reset),
                .load      (skid_load_s),
                .clear     (skid_clear_s),
                .next_ctrl (in_ctrl),
                .next_data (in_data),
                .valid     (skid_valid_s),
                .ctrl      (skid_ctrl_s),
                .data      (skid_data_s)
            );
            assign in_ready = in_ready_r;
        end else begin : g_single
            assign skid_valid_s = 1'b0;
            assign skid_ctrl_s  = '0;
            assign skid_data_s  = '0;
            assign in_ready     = !main_valid_s || out_ready;
        end
    endgenerate

    // Next-state and slot-control decode. Flush overrides accept and release.
    always_comb begin
        state_next_s     = state_r;
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush) begin
            state_next_s = EMPTY;
            main_clear_s = 1'b1;
            skid_clear_s = 1'b1;
        end else if (SKID != 0) begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        main_load_s  = 1'b1;
                        state_next_s = ONE;
                    end else begin
                        state_next_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && release_s) begin
                        main_load_s  = 1'b1;
                        state_next_s = ONE;
                    end else if (accept_s) begin
                        skid_load_s  = 1'b1;
                        state_next_s = TWO;
                    end else if (release_s) begin
                        main_clear_s = 1'b1;
                        state_next_s = EMPTY;
                    end else begin
                        state_next_s = ONE;
                    end
                end
                TWO: begin
                    if (release_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        skid_clear_s     = 1'b1;
                        state_next_s     = ONE;
                    end else begin
                        state_next_s = TWO;
                    end
                end
                default: begin
                    state_next_s = EMPTY;
                    main_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end
            endcase
        end else begin
            if (accept_s) begin
                main_load_s  = 1'b1;
                state_next_s = ONE;
            end else if (release_s) begin
                main_clear_s = 1'b1;
                state_next_s = EMPTY;
            end else begin
                state_next_s = state_r;
            end
        end
    end

    // State register. occupancy and in_ready are registered alongside it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= EMPTY;
            occupancy_r <= 2'd0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            occupancy_r <= state_occupancy(state_next_s);
            in_ready_r  <= (state_next_s != TWO);
        end
    end

    assign out_valid = main_valid_s;
    assign out_data  = main_data_s;
    assign out_ctrl  = main_ctrl_s & {CTRL_W{main_valid_s}};
    assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. u_dut runs in SKID=1 mode and u_dut0
// runs in SKID=0 mode. Both share the clock and reset.
module tb_pipe_stage_skid;

    logic         clk;
    logic         reset;

    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [196:0] in_data;
    logic [5:0]   in_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [196:0] out_data;
    logic [5:0]   out_ctrl;
    logic [1:0]   occupancy;

    logic         s0_flush;
    logic         s0_in_valid;
    logic         s0_in_ready;
    logic [31:0]  s0_in_data;
    logic [5:0]   s0_in_ctrl;
    logic         s0_out_valid;
    logic         s0_out_ready;
    logic [31:0]  s0_out_data;
    logic [5:0]   s0_out_ctrl;
    logic [1:0]   s0_occupancy;

    int           checks_r;
    int           failures_r;

    pipe_stage_skid #(.DATA_W(197), .CTRL_W(6), .SKID(1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    pipe_stage_skid #(.DATA_W(32), .CTRL_W(6), .SKID(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .flush     (s0_flush),
        .in_valid  (s0_in_valid),
        .in_ready  (s0_in_ready),
        .in_data   (s0_in_data),
        .in_ctrl   (s0_in_ctrl),
        .out_valid (s0_out_valid),
        .out_ready (s0_out_ready),
        .out_data  (s0_out_data),
        .out_ctrl  (s0_out_ctrl),
        .occupancy (s0_occupancy)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample point is 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        checks_r     = 0;
        failures_r   = 0;
        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_ctrl      = 6'd0;
        out_ready    = 1'b1;
        s0_flush     = 1'b0;
        s0_in_valid  = 1'b0;
        s0_in_data   = 32'd0;
        s0_in_ctrl   = 6'd0;
        s0_out_ready = 1'b1;

        // Reset state
        #12;
        check_eq("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check_eq("rst_out_ctrl",  256'(out_ctrl),  256'(6'd0));
        check_eq("rst_out_data",  256'(out_data),  256'(0));
        check_eq("rst_in_ready",  256'(in_ready),  256'(1'b1));
        check_eq("rst_occ",       256'(occupancy), 256'(2'd0));
        check_eq("rst_s0_ready",  256'(s0_in_ready), 256'(1'b1));
        reset = 1'b0;
        tick();

        // Single beat
        in_valid = 1'b1;
        in_data  = 197'h0DEAD_BEEF;
        in_ctrl  = 6'b101010;
        tick();
        in_valid = 1'b0;
        check_eq("one_valid", 256'(out_valid), 256'(1'b1));
        check_eq("one_data",  256'(out_data),  256'h0DEAD_BEEF);
        check_eq("one_ctrl",  256'(out_ctrl),  256'(6'b101010));
        check_eq("one_occ",   256'(occupancy), 256'(2'd1));
        tick();
        check_eq("one_drain_valid", 256'(out_valid), 256'(1'b0));
        check_eq("one_drain_ctrl",  256'(out_ctrl),  256'(6'd0));
        check_eq("one_drain_occ",   256'(occupancy), 256'(2'd0));

        // Streaming 8 beats at full rate
        in_valid = 1'b1;
        in_data  = 197'd0;
        in_ctrl  = 6'd1;
        for (int i = 0; i < 8; i++) begin
            check_eq("stream_in_ready", 256'(in_ready), 256'(1'b1));
            tick();
            check_eq("stream_valid", 256'(out_valid), 256'(1'b1));
            check_eq("stream_data",  256'(out_data),  256'(i));
            if (i < 7) begin
                in_data = 197'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        check_eq("stream_end_valid", 256'(out_valid), 256'(1'b0));

        // Backpressure: exactly one extra beat absorbed, then FIFO drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 197'd100;
        in_ctrl   = 6'd3;
        tick();
        check_eq("bp_ready_one", 256'(in_ready),  256'(1'b1));
        check_eq("bp_occ_one",   256'(occupancy), 256'(2'd1));
        in_data = 197'd101;
        tick();
        check_eq("bp_ready_two", 256'(in_ready),  256'(1'b0));
        check_eq("bp_occ_two",   256'(occupancy), 256'(2'd2));
        check_eq("bp_head",      256'(out_data),  256'(100));
        in_data = 197'd102;
        tick();
        check_eq("bp_hold_occ",  256'(occupancy), 256'(2'd2));
        check_eq("bp_hold_data", 256'(out_data),  256'(100));
        check_eq("bp_hold_ctrl", 256'(out_ctrl),  256'(6'd3));
        out_ready = 1'b1;
        tick();
        check_eq("bp_rel1_data",  256'(out_data),  256'(101));
        check_eq("bp_rel1_ready", 256'(in_ready),  256'(1'b1));
        check_eq("bp_rel1_occ",   256'(occupancy), 256'(2'd1));
        tick();
        in_valid = 1'b0;
        check_eq("bp_rel2_data",  256'(out_data),  256'(102));
        check_eq("bp_rel2_valid", 256'(out_valid), 256'(1'b1));
        tick();
        check_eq("bp_empty_valid", 256'(out_valid), 256'(1'b0));

        // Flush in TWO with an incoming beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 197'd200;
        in_ctrl   = 6'd7;
        tick();
        in_data = 197'd201;
        tick();
        check_eq("fl_pre_occ", 256'(occupancy), 256'(2'd2));
        flush   = 1'b1;
        in_data = 197'd202;
        #1;
        check_eq("fl_cycle_valid", 256'(out_valid), 256'(1'b1));
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("fl_valid", 256'(out_valid), 256'(1'b0));
        check_eq("fl_ctrl",  256'(out_ctrl),  256'(6'd0));
        check_eq("fl_occ",   256'(occupancy), 256'(2'd0));
        check_eq("fl_ready", 256'(in_ready),  256'(1'b1));
        tick();
        check_eq("fl_no_ghost", 256'(out_valid), 256'(1'b0));

        // Reset while occupancy is 2
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 197'd300;
        in_ctrl   = 6'd9;
        tick();
        in_data = 197'd301;
        tick();
        in_valid = 1'b0;
        check_eq("rs_pre_occ", 256'(occupancy), 256'(2'd2));
        #1;
        reset = 1'b1;
        #1;
        check_eq("rs_valid", 256'(out_valid), 256'(1'b0));
        check_eq("rs_data",  256'(out_data),  256'(0));
        check_eq("rs_ctrl",  256'(out_ctrl),  256'(6'd0));
        check_eq("rs_occ",   256'(occupancy), 256'(2'd0));
        check_eq("rs_ready", 256'(in_ready),  256'(1'b1));
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();

        // SKID=0: combinational ready and same-cycle replacement
        s0_out_ready = 1'b0;
        s0_in_valid  = 1'b1;
        s0_in_data   = 32'h11;
        s0_in_ctrl   = 6'd5;
        tick();
        s0_in_valid = 1'b0;
        check_eq("s0_valid",     256'(s0_out_valid), 256'(1'b1));
        check_eq("s0_occ",       256'(s0_occupancy), 256'(2'd1));
        check_eq("s0_ready_low", 256'(s0_in_ready),  256'(1'b0));
        s0_out_ready = 1'b1;
        #1;
        check_eq("s0_ready_comb", 256'(s0_in_ready), 256'(1'b1));
        s0_in_valid = 1'b1;
        s0_in_data  = 32'h22;
        s0_in_ctrl  = 6'd6;
        tick();
        s0_in_valid = 1'b0;
        check_eq("s0_repl_valid", 256'(s0_out_valid), 256'(1'b1));
        check_eq("s0_repl_data",  256'(s0_out_data),  256'(32'h22));
        check_eq("s0_repl_ctrl",  256'(s0_out_ctrl),  256'(6'd6));
        tick();
        check_eq("s0_drain_valid", 256'(s0_out_valid), 256'(1'b0));
        check_eq("s0_drain_occ",   256'(s0_occupancy), 256'(2'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
